// File: rtl/uart_rx_core_if.sv
`default_nettype none
// ============================================================================
// uart_rx_core_if : host/line-side signal bundle of the UART receive core
// Rev 1.0
// ============================================================================
interface uart_rx_core_if #(
  parameter int DBIT   = 8,
  parameter int DVSR_W = 11
);
  logic [DVSR_W-1:0] dvsr;
  logic              rx;
  logic [DBIT-1:0]   dout;
  logic              rx_done_tick;
  logic              frame_err;
  logic              busy;

  modport master (
    output dvsr, rx,
    input  dout, rx_done_tick, frame_err, busy
  );

  modport slave (
    input  dvsr, rx,
    output dout, rx_done_tick, frame_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// uart_rx_core : 16x-oversampled UART deframer with its own baud tick
// Rev 1.0
// ============================================================================
module uart_rx_core #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR_W  = 11
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_core_if.slave bus
);
  localparam int C_S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int C_N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [C_S_W-1:0] C_S_MID  = C_S_W'(7);
  localparam logic [C_S_W-1:0] C_S_BIT  = C_S_W'(15);
  localparam logic [C_S_W-1:0] C_S_STOP = C_S_W'(SB_TICK - 1);
  localparam logic [C_N_W-1:0] C_N_LAST = C_N_W'(DBIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [1:0]        r_sync;
  logic [DVSR_W-1:0] r_cnt;
  state_t            r_state;
  logic [C_S_W-1:0]  r_s;
  logic [C_N_W-1:0]  r_n;
  logic [DBIT-1:0]   r_shreg;
  logic [DBIT-1:0]   r_dout;
  logic              r_done;
  logic              r_ferr;
  logic              r_busy;
  logic              w_rx_s;
  logic              w_tick;

  assign w_rx_s = r_sync[1];
  // >= rather than == so a divisor lowered below the running count still fires
  assign w_tick = (r_cnt >= bus.dvsr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
      r_cnt  <= w_tick ? '0 : r_cnt + DVSR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_s     <= '0;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_s == C_S_MID) begin
              if (!w_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_s <= r_s + C_S_W'(1);
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_s == C_S_BIT) begin
              r_s     <= '0;
              r_shreg <= {w_rx_s, r_shreg[DBIT-1:1]};
              if (r_n == C_N_LAST) begin
                r_state <= STOP;
              end else begin
                r_n <= r_n + C_N_W'(1);
              end
            end else begin
              r_s <= r_s + C_S_W'(1);
            end
          end
        end
        STOP: begin
          if (w_tick) begin
            if (r_s == C_S_STOP) begin
              r_dout  <= r_shreg;
              r_ferr  <= ~w_rx_s;
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_s <= r_s + C_S_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign bus.dout         = r_dout;
  assign bus.rx_done_tick = r_done;
  assign bus.frame_err    = r_ferr;
  assign bus.busy         = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_core : randomized frame stimulus checked against a frame-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_core;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int DVSR_W  = 11;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_core_if #(.DBIT(DBIT), .DVSR_W(DVSR_W)) bus ();

  uart_rx_core #(.DBIT(DBIT), .SB_TICK(SB_TICK), .DVSR_W(DVSR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder: every rx_done_tick captured with its data and clock index
  int         strobe_cnt  = 0;
  int         wide_cnt    = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] got_data[$];
  logic       got_ferr[$];
  int         got_cyc[$];

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      strobe_cnt++;
      got_data.push_back(bus.dout);
      got_ferr.push_back(bus.frame_err);
      got_cyc.push_back(cyc);
      if (prev_strobe) wide_cnt++;
    end
    prev_strobe = (bus.rx_done_tick === 1'b1);
  end

  // Line driver; entered and left on a falling clock edge
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input int bitclk, input int gap);
    last_start = cyc;
    bus.rx = 1'b0;
    repeat (bitclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      repeat (bitclk) @(negedge clk);
    end
    if (stop_ok) begin
      bus.rx = 1'b1;
      repeat (bitclk) @(negedge clk);
    end else begin
      bus.rx = 1'b0;
      repeat (3 * bitclk / 4) @(negedge clk);
      bus.rx = 1'b1;
      repeat (bitclk - 3 * bitclk / 4) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    rst      = 1'b0;
    bus.rx   = 1'b1;
    bus.dvsr = 11'd3;
    repeat (4) @(negedge clk);
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
    checks++; if (bus.rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b expected 0", bus.rx_done_tick); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    rst = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_basic;
    int base;
    int lat;
    base = strobe_cnt;
    send_frame(8'hA5, 1'b1, 64, 64);
    checks++; if (strobe_cnt !== base + 1) begin errors++; $display("FAIL basic_count: got %0d strobes expected %0d", strobe_cnt - base, 1); end
    if (got_data.size() > base) begin
      lat = got_cyc[base] - last_start;
      checks++; if (got_data[base] !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", got_data[base]); end
      checks++; if (got_ferr[base] !== 1'b0) begin errors++; $display("FAIL basic_ferr: got %b expected 0", got_ferr[base]); end
      checks++; if (lat < 151 * 4 + 4 || lat > 152 * 4 + 3) begin errors++; $display("FAIL basic_latency: got %0d expected %0d..%0d", lat, 151 * 4 + 4, 152 * 4 + 3); end
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_glitch;
    int base;
    base = strobe_cnt;
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", bus.busy); end
    bus.rx = 1'b1;
    repeat (128) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", bus.busy); end
    checks++; if (strobe_cnt !== base) begin errors++; $display("FAIL glitch_strobe: got %0d strobes expected 0", strobe_cnt - base); end
    checks++; if (bus.dout !== 8'hA5) begin errors++; $display("FAIL glitch_dout: got %h expected a5", bus.dout); end
  endtask

  task automatic test_frame_err;
    int base;
    base = strobe_cnt;
    send_frame(8'h3C, 1'b0, 64, 128);
    checks++; if (strobe_cnt !== base + 1) begin errors++; $display("FAIL ferr_count: got %0d strobes expected 1", strobe_cnt - base); end
    checks++; if (bus.dout !== 8'h3C) begin errors++; $display("FAIL ferr_dout: got %h expected 3c", bus.dout); end
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b expected 1", bus.frame_err); end
    send_frame(8'h3C, 1'b1, 64, 64);
    checks++; if (strobe_cnt !== base + 2) begin errors++; $display("FAIL ferr_count2: got %0d strobes expected 2", strobe_cnt - base); end
    checks++; if (bus.dout !== 8'h3C) begin errors++; $display("FAIL ferr_dout2: got %h expected 3c", bus.dout); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b expected 0", bus.frame_err); end
  endtask

  task automatic test_back_to_back;
    int base;
    base = strobe_cnt;
    send_frame(8'h00, 1'b1, 64, 0);
    send_frame(8'hFF, 1'b1, 64, 64);
    checks++; if (strobe_cnt !== base + 2) begin errors++; $display("FAIL b2b_count: got %0d strobes expected 2", strobe_cnt - base); end
    if (got_data.size() > base + 1) begin
      checks++; if (got_data[base] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", got_data[base]); end
      checks++; if (got_data[base + 1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", got_data[base + 1]); end
      checks++; if (got_cyc[base + 1] - got_cyc[base] !== 640) begin errors++; $display("FAIL b2b_spacing: got %0d clk expected 640", got_cyc[base + 1] - got_cyc[base]); end
    end
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width: got %0d wide strobes expected 0", wide_cnt); end
  endtask

  task automatic test_reset_mid;
    int base;
    logic [7:0] d;
    d    = {4'hF, 4'($urandom_range(0, 15))};
    base = strobe_cnt;
    bus.rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = d[i];
      repeat (64) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (32) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h expected 00", bus.dout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b expected 0", bus.frame_err); end
    repeat (31 + 3 * 64 + 64 + 64) @(negedge clk);
    checks++; if (strobe_cnt !== base) begin errors++; $display("FAIL rstmid_strobe: got %0d strobes expected 0", strobe_cnt - base); end
    send_frame(8'h5A, 1'b1, 64, 64);
    checks++; if (strobe_cnt !== base + 1) begin errors++; $display("FAIL rstmid_next_count: got %0d strobes expected 1", strobe_cnt - base); end
    checks++; if (bus.dout !== 8'h5A) begin errors++; $display("FAIL rstmid_next_dout: got %h expected 5a", bus.dout); end
  endtask

  task automatic test_dvsr;
    int base;
    int lat;
    base = strobe_cnt;
    bus.dvsr = 11'd0;
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b1, 16, 32);
    checks++; if (strobe_cnt !== base + 1) begin errors++; $display("FAIL dvsr0_count: got %0d strobes expected 1", strobe_cnt - base); end
    checks++; if (bus.dout !== 8'h81) begin errors++; $display("FAIL dvsr0_dout: got %h expected 81", bus.dout); end
    if (got_cyc.size() > base) begin
      lat = got_cyc[base] - last_start;
      checks++; if (lat !== 155) begin errors++; $display("FAIL dvsr0_latency: got %0d expected 155", lat); end
    end
    bus.dvsr = 11'd68;
    repeat (4) @(negedge clk);
    send_frame(8'h81, 1'b1, 1104, 1104);
    checks++; if (strobe_cnt !== base + 2) begin errors++; $display("FAIL dvsr68_count: got %0d strobes expected 2", strobe_cnt - base); end
    checks++; if (bus.dout !== 8'h81) begin errors++; $display("FAIL dvsr68_dout: got %h expected 81", bus.dout); end
    if (got_cyc.size() > base + 1) begin
      lat = got_cyc[base + 1] - last_start;
      checks++; if (lat < 151 * 69 + 4 || lat > 152 * 69 + 3) begin errors++; $display("FAIL dvsr68_latency: got %0d expected %0d..%0d", lat, 151 * 69 + 4, 152 * 69 + 3); end
    end
  endtask

  // Frame-level model: each full frame yields (data, ~stop), strobing at mid-stop
  task automatic test_random;
    for (int b = 0; b < 2; b++) begin
      logic [7:0] exp_data[$];
      logic       exp_ferr[$];
      int         exp_start[$];
      int p, bitclk, base, gap, lat;
      logic [7:0] d;
      logic ok;
      p      = $urandom_range(1, 5);
      bitclk = 16 * p;
      bus.dvsr = 11'(p - 1);
      repeat (8) @(negedge clk);
      base = strobe_cnt;
      for (int f = 0; f < 5; f++) begin
        d   = 8'($urandom_range(0, 255));
        ok  = ($urandom_range(0, 3) != 0);
        gap = ok ? $urandom_range(0, 1) * $urandom_range(0, bitclk) : 2 * bitclk;
        send_frame(d, ok, bitclk, gap);
        exp_data.push_back(d);
        exp_ferr.push_back(~ok);
        exp_start.push_back(last_start);
      end
      repeat (2 * bitclk) @(negedge clk);
      checks++; if (strobe_cnt !== base + 5) begin errors++; $display("FAIL rand_count: batch %0d got %0d strobes expected 5", b, strobe_cnt - base); end
      for (int f = 0; f < 5; f++) begin
        if (got_data.size() > base + f) begin
          lat = got_cyc[base + f] - exp_start[f];
          checks++; if (got_data[base + f] !== exp_data[f]) begin errors++; $display("FAIL rand_data: batch %0d frame %0d got %h expected %h", b, f, got_data[base + f], exp_data[f]); end
          checks++; if (got_ferr[base + f] !== exp_ferr[f]) begin errors++; $display("FAIL rand_ferr: batch %0d frame %0d got %b expected %b", b, f, got_ferr[base + f], exp_ferr[f]); end
          checks++; if (lat < 151 * p + 4 || lat > 152 * p + 3) begin errors++; $display("FAIL rand_latency: batch %0d frame %0d got %0d expected %0d..%0d", b, f, lat, 151 * p + 4, 152 * p + 3); end
        end
      end
    end
  endtask

  initial begin
    bus.rx   = 1'b1;
    bus.dvsr = 11'd3;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_dvsr();
    test_random();
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL strobe_width_final: got %0d wide strobes expected 0", wide_cnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
